dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Target side of the core's data-memory interface: the load/store unit issues requests; this block answers them.
- Word-organised on-chip RAM with byte-strobe writes, programmable wait states, and access-fault responses.
- Out-of-range and instruction-fetch accesses are answered with an error, which the load/store unit converts into a load/store access-fault trap.
- Sits between the core's mem_in/mem_out data port and the platform; one request outstanding at a time.

Parameters:
DEPTH, 4096, RAM size in 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4 aligned)
WAIT_STATES, 0, extra cycles between accept and response (0..15)
RO_BYTES, 0, bytes from BASE_ADDR that are write-protected (used only with optional feature)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
mem_valid  in  1  request strobe, sampled only in IDLE
mem_instr  in  1  1 = instruction fetch (always faulted)
mem_addr  in  32  byte address; bits [1:0] ignored for word select
mem_wdata  in  32  write data, byte lanes per mem_wstrb
mem_wstrb  in  4  byte enables; 0 = read, nonzero = write
mem_rdata  out  32  read data, valid while mem_ready=1
mem_ready  out  1  one-cycle response pulse
mem_error  out  1  fault flag, valid while mem_ready=1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. With reset=0 at a rising edge, the state becomes IDLE and mem_ready=0, mem_error=0, mem_rdata=0. RAM contents are not reset.
- Outputs: all are registered.
- States:
  - IDLE: mem_valid=1 captures addr/wdata/wstrb/instr.
    - WAIT_STATES=0 -> RESP.
    - Otherwise -> WAIT with cnt=WAIT_STATES-1.
  - WAIT: cnt decrements each cycle; at cnt=0 -> RESP.
  - RESP: not a visible state. On the edge that enters it, the block sets mem_ready=1 for exactly one cycle and returns to IDLE on that same edge.
- Latency and throughput:
  - Request in cycle N -> mem_ready=1 in cycle N+1+WAIT_STATES.
  - The cycle in which mem_ready=1 is an IDLE cycle, so a new request can be accepted there.
  - With WAIT_STATES=0, throughput is one request per cycle.
- Busy handling: mem_valid is ignored in WAIT. The initiator holds the stall until mem_ready; requests arriving in WAIT are dropped, not queued.
- Fault checks, evaluated on the captured request:
  - err = mem_instr | (addr < BASE_ADDR) | (addr >= BASE_ADDR+DEPTH*4).
  - The faulted check from the optional feature is ORed into err when compiled in.
- Read (wstrb=0): mem_rdata = RAM[(addr-BASE_ADDR)>>2], full word; the load unit extracts sub-words. If err, mem_rdata=0.
- Write (wstrb≠0):
  - Each byte lane i with wstrb[i]=1 gets wdata[8i+7:8i].
  - The commit happens on the same edge that raises mem_ready.
  - If err, there is no write; mem_rdata=0 during the response.
- Response fields: mem_error=err; mem_ready=1 regardless of err. An error response never lasts more than one cycle.
- Read-after-write, same word, back-to-back: the read returns the new data (the write committed before the read is sampled).
- Address arithmetic: all 32-bit unsigned. The range compare must not wrap; the upper limit is computed in 33 bits.
- Reset mid-operation: a pending request in WAIT is discarded, no write occurs, and no mem_ready is produced.
- Between responses, mem_ready=0 and mem_error=0. mem_rdata holds its last value (don't-care).

Optional Feature:
- Macro: DMEM_WRITE_PROTECT_EN.
- Defined:
  - A write with BASE_ADDR <= addr < BASE_ADDR+RO_BYTES sets err=1 (store access fault) and does not modify RAM.
  - Reads of that region are unaffected.
- Undefined: RO_BYTES is ignored and all in-range writes commit.

Test Plan:
- Reset, then a write and read with WAIT_STATES=0:
  - Stimulus: reset=0 for 2 cycles, then write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF in cycle 5.
  - Required: mem_ready=1, mem_error=0 in cycle 6.
  - Then: read 0x10 in cycle 6 -> mem_ready=1, mem_rdata=0xDEADBEEF in cycle 7.
- Byte strobes:
  - Stimulus: after the above, write 0x10 with wdata 0x00AA0000, wstrb 4'b0100, then read 0x10.
  - Required: mem_rdata=0xDEAABEEF.
- Wait states:
  - Stimulus: WAIT_STATES=3, read issued in cycle N.
  - Required: mem_ready=0 in N+1..N+3, mem_ready=1 in N+4 only. A second mem_valid pulse in N+2 produces no extra response.
- Faults:
  - Stimulus: read at BASE_ADDR+DEPTH*4.
  - Required: mem_ready=1, mem_error=1, mem_rdata=0.
  - Stimulus: mem_instr=1 to 0x0.
  - Required: mem_error=1.
  - Stimulus: out-of-range write, then an in-range readback of all words.
  - Required: RAM unchanged.
- Reset mid-request:
  - Stimulus: WAIT_STATES=4, write 0x20 with 0x12345678; reset=0 in cycle 2 of WAIT.
  - Required: no mem_ready. A later read of 0x20 returns the prior contents.
- Write protect (DMEM_WRITE_PROTECT_EN, RO_BYTES=0x100):
  - Stimulus: write 0x80.
  - Required: mem_error=1 and data unchanged.
  - Stimulus: write 0x100.
  - Required: mem_error=0 and commits.
  - Without the macro: the write to 0x80 commits with mem_error=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder -- target side of the core's data-memory port.
//
// Word-organised on-chip RAM with byte-strobe writes, a fixed number of
// wait states per access, and an error response for instruction fetches
// and out-of-range addresses. Only one request is in flight at a time.
//
// Optional feature (compile-time macro DMEM_WRITE_PROTECT_EN): writes to
// the first RO_BYTES bytes above BASE_ADDR are refused with mem_error=1.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   mem_valid  request strobe (sampled only while idle)
//   mem_instr  1 = instruction fetch (always faulted)
//   mem_addr   byte address, bits [1:0] ignored for word select
//   mem_wdata  write data
//   mem_wstrb  byte enables, 0 = read
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  one-cycle response pulse
//   mem_error  fault flag, valid with mem_ready
module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_BYTES    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Upper limit kept in 33 bits so a region ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT  = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
  localparam logic [32:0] RO_LIM = 33'(RO_BYTES);

`ifdef DMEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  dmem_req_t   req_in, req_q, act;
  logic        fire;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        range_err, ro_hit, err, is_wr, we;

  logic [3:0][7:0] ram [DEPTH];

  assign req_in = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};

  // With no wait states the response is produced on the accepting edge,
  // so the live request is used directly instead of the captured copy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    act       = req_q;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          if (WAIT_STATES == 0) begin
            fire = 1'b1;
            act  = req_in;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          fire      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign offset    = act.addr - BASE_ADDR;
  assign idx       = offset[AW+1:2];
  assign is_wr     = |act.wstrb;
  assign range_err = ({1'b0, act.addr} < {1'b0, BASE_ADDR}) | ({1'b0, act.addr} >= LIMIT);
  assign ro_hit    = WP_EN & is_wr & ({1'b0, offset} < RO_LIM);
  assign err       = act.instr | range_err | ro_hit;
  // Gate with reset so an edge that also resets never commits a write.
  assign we        = fire & is_wr & ~err & reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= fire;
      mem_error <= fire & err;
      if (fire) mem_rdata <= (err || is_wr) ? 32'd0 : ram[idx];
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_IDLE && mem_valid) req_q <= req_in;
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we && act.wstrb[i]) ram[idx][i] <= act.wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances share the request
// bus; each has its own strobe and reset:
//   u0: WAIT_STATES=0, DEPTH=64,  BASE=0x0000
//   u1: WAIT_STATES=3, DEPTH=128, BASE=0x0000, RO_BYTES=0x100
//   u2: WAIT_STATES=4, DEPTH=64,  BASE=0x2000
module tb_dmem_responder;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]       rst_n, vld, rdy, err;
  logic             instr;
  logic [31:0]      addr, wdata;
  logic [3:0]       wstrb;
  logic [2:0][31:0] rdata;
  int n_tests = 0, n_fail = 0;
  int ws [3] = '{0, 3, 4};

  dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RO_BYTES(0)) u0 (
    .clock(clock), .reset(rst_n[0]), .mem_valid(vld[0]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_error(err[0]));
  dmem_responder #(.DEPTH(128), .BASE_ADDR(32'h0), .WAIT_STATES(3), .RO_BYTES(256)) u1 (
    .clock(clock), .reset(rst_n[1]), .mem_valid(vld[1]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_error(err[1]));
  dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h2000), .WAIT_STATES(4), .RO_BYTES(0)) u2 (
    .clock(clock), .reset(rst_n[2]), .mem_valid(vld[2]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .mem_error(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call at #1 after a rising edge; returns at #1 after the response edge.
  task automatic xact(input int u, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ins,
                      output logic [31:0] r, output logic e);
    int lat = 0;
    addr = a; wdata = d; wstrb = s; instr = ins; vld[u] = 1'b1;
    r = '0; e = 1'b0;
    do begin
      @(posedge clock); #1;
      vld[u] = 1'b0;
      lat++;
    end while (!rdy[u] && lat < 30);
    if (!rdy[u]) chk("timeout", 32'(lat), 32'(1 + ws[u]));
    else begin
      chk("latency", 32'(lat), 32'(1 + ws[u]));
      r = rdata[u];
      e = err[u];
    end
    instr = 1'b0;
  endtask

  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic exp_err, input string tag);
    logic [31:0] r; logic e;
    xact(u, a, d, s, 1'b0, r, e);
    chk({tag, ".err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd(input int u, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic exp_err, input string tag);
    logic [31:0] r; logic e;
    xact(u, a, 32'h0, 4'h0, 1'b0, r, e);
    chk({tag, ".err"}, 32'(e), 32'(exp_err));
    chk({tag, ".data"}, r, exp_d);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, pre;
    logic e;
    int cnt;
    rst_n = '0; vld = '0; addr = '0; wdata = '0; wstrb = '0; instr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.ready", 32'(rdy), 32'h0);
    chk("rst.error", 32'(err), 32'h0);
    chk("rst.rdata0", rdata[0], 32'h0);
    chk("rst.rdata2", rdata[2], 32'h0);
    rst_n = '1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle.ready", 32'(rdy), 32'h0);

    // back-to-back write/read and byte strobes, zero wait states
    wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "w0");
    rd(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "r0");
    wr(0, 32'h10, 32'h00AA_0000, 4'b0100, 1'b0, "wb2");
    rd(0, 32'h10, 32'hDEAA_BEEF, 1'b0, "rb2");
    wr(0, 32'h14, 32'h1122_3344, 4'hF, 1'b0, "w14");
    wr(0, 32'h17, 32'hAABB_CCDD, 4'b1001, 1'b0, "wb03");
    rd(0, 32'h15, 32'hAA22_33DD, 1'b0, "rb03");

    // fault responses
    rd(0, 32'h100, 32'h0, 1'b1, "oob");
    rd(0, 32'hFFFF_FFFC, 32'h0, 1'b1, "wrap");
    xact(0, 32'h0, 32'h0, 4'h0, 1'b1, r, e);
    chk("ifetch.err", 32'(e), 32'h1);
    chk("ifetch.data", r, 32'h0);

    // fill, faulted writes, then full readback
    for (int i = 0; i < 64; i++) wr(0, 32'(i * 4), pat(i), 4'hF, 1'b0, "fill");
    wr(0, 32'h100, 32'hBAD0_BAD0, 4'hF, 1'b1, "oobw");
    wr(0, 32'hFFFF_FFFC, 32'hBAD1_BAD1, 4'hF, 1'b1, "wrapw");
    xact(0, 32'h8, 32'hBAD2_BAD2, 4'hF, 1'b1, r, e);
    chk("ifetchw.err", 32'(e), 32'h1);
    for (int i = 0; i < 64; i++) rd(0, 32'(i * 4), pat(i), 1'b0, "rbk");
    chk("between.error", 32'(err[0]), 32'h0);

    // wait states: response only in N+4, a pulse in N+2 is dropped
    wr(1, 32'h40, 32'h0BAD_F00D, 4'hF, 1'b0, "w40");
    addr = 32'h40; wstrb = 4'h0; vld[1] = 1'b1;
    @(posedge clock); #1; vld[1] = 1'b0;
    chk("ws.n1", 32'(rdy[1]), 32'h0);
    @(posedge clock); #1;
    chk("ws.n2", 32'(rdy[1]), 32'h0);
    addr = 32'h44; vld[1] = 1'b1;
    @(posedge clock); #1; vld[1] = 1'b0;
    chk("ws.n3", 32'(rdy[1]), 32'h0);
    @(posedge clock); #1;
    chk("ws.n4", 32'(rdy[1]), 32'h1);
    chk("ws.data", rdata[1], 32'h0BAD_F00D);
    chk("ws.err", 32'(err[1]), 32'h0);
    cnt = 0;
    repeat (8) begin @(posedge clock); #1; cnt += int'(rdy[1]); end
    chk("ws.extra", 32'(cnt), 32'h0);

    // write protect region on u1
    xact(1, 32'h80, 32'h0, 4'h0, 1'b0, pre, e);
    chk("wp.rd.err", 32'(e), 32'h0);
`ifdef DMEM_WRITE_PROTECT_EN
    wr(1, 32'h80, 32'h5A5A_5A5A, 4'hF, 1'b1, "wp80");
    rd(1, 32'h80, pre, 1'b0, "wp80r");
`else
    wr(1, 32'h80, 32'h5A5A_5A5A, 4'hF, 1'b0, "wp80");
    rd(1, 32'h80, 32'h5A5A_5A5A, 1'b0, "wp80r");
`endif
    wr(1, 32'h100, 32'h600D_CAFE, 4'hF, 1'b0, "wp100");
    rd(1, 32'h100, 32'h600D_CAFE, 1'b0, "wp100r");

    // reset during WAIT on u2 discards the request
    wr(2, 32'h2020, 32'hCAFE_F00D, 4'hF, 1'b0, "w2020");
    addr = 32'h2020; wdata = 32'h1234_5678; wstrb = 4'hF; vld[2] = 1'b1;
    @(posedge clock); #1; vld[2] = 1'b0;
    @(posedge clock); #1; rst_n[2] = 1'b0;
    @(posedge clock); #1; rst_n[2] = 1'b1;
    cnt = int'(rdy[2]);
    repeat (8) begin @(posedge clock); #1; cnt += int'(rdy[2]); end
    chk("rstmid.ready", 32'(cnt), 32'h0);
    rd(2, 32'h2020, 32'hCAFE_F00D, 1'b0, "rstmid.r");

    // u2 range edges with non-zero base
    rd(2, 32'h1FFC, 32'h0, 1'b1, "below");
    wr(2, 32'h20FC, 32'h1357_9BDF, 4'hF, 1'b0, "wlast");
    rd(2, 32'h20FC, 32'h1357_9BDF, 1'b0, "rlast");
    rd(2, 32'h2100, 32'h0, 1'b1, "above");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
